// File: rtl/lcd_cls_cmd_serializer.sv
// Serialises LCD clear / line-write escape sequences into a byte stream with a valid/ready handshake.
// Optional LCD_CLS_TEXT_LATCH_EN latches the selected line text when the command is accepted.
module lcd_cls_cmd_serializer (
  input  logic         i_clk_20mhz,
  input  logic         i_rst_20mhz,
  input  logic         i_ce_2_5mhz,
  input  logic         i_cmd_wr_clear_display,
  input  logic         i_cmd_wr_text_line1,
  input  logic         i_cmd_wr_text_line2,
  input  logic [127:0] i_dat_ascii_line1,
  input  logic [127:0] i_dat_ascii_line2,
  output logic         o_command_ready,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_valid,
  input  logic         i_tx_ready,
  output logic         o_cmd_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_DONE} state_e;

  localparam logic [1:0] CmdClear = 2'd0;
  localparam logic [1:0] CmdLine1 = 2'd1;
  localparam logic [1:0] CmdLine2 = 2'd2;

  state_e       state_q, state_d;
  logic [1:0]   cmd_q, cmd_d;
  logic [4:0]   idx_q, idx_d;
  logic         tx_valid_q, tx_valid_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic [127:0] text_sel;
  logic [4:0]   last_idx;

`ifdef LCD_CLS_TEXT_LATCH_EN
  logic [127:0] text_q, text_d;
  assign text_sel = text_q;
`else
  assign text_sel = (cmd_q == CmdLine2) ? i_dat_ascii_line2 : i_dat_ascii_line1;
`endif

  // Byte idx of the sequence for a command; chars start at idx 6, leftmost in the MSBs.
  function automatic logic [7:0] cmd_byte(input logic [1:0]   cmd,
                                          input logic [4:0]   idx,
                                          input logic [127:0] text);
    logic [3:0] c;
    c = 4'(idx - 5'd6);
    if (cmd == CmdClear) begin
      case (idx)
        5'd0:    cmd_byte = 8'h1B;
        5'd1:    cmd_byte = 8'h5B;
        default: cmd_byte = 8'h6A;
      endcase
    end else begin
      case (idx)
        5'd0:    cmd_byte = 8'h1B;
        5'd1:    cmd_byte = 8'h5B;
        5'd2:    cmd_byte = (cmd == CmdLine2) ? 8'h31 : 8'h30;
        5'd3:    cmd_byte = 8'h3B;
        5'd4:    cmd_byte = 8'h30;
        5'd5:    cmd_byte = 8'h48;
        default: cmd_byte = text[{~c, 3'b000} +: 8];
      endcase
    end
  endfunction

  assign last_idx = (cmd_q == CmdClear) ? 5'd2 : 5'd21;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    idx_d      = idx_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
`ifdef LCD_CLS_TEXT_LATCH_EN
    text_d     = text_q;
`endif
    if (i_ce_2_5mhz) begin
      case (state_q)
        ST_IDLE: begin
          if (i_cmd_wr_clear_display || i_cmd_wr_text_line1 || i_cmd_wr_text_line2) begin
            cmd_d   = i_cmd_wr_clear_display ? CmdClear :
                      i_cmd_wr_text_line1    ? CmdLine1 : CmdLine2;
            idx_d   = 5'd0;
            state_d = ST_LOAD;
`ifdef LCD_CLS_TEXT_LATCH_EN
            text_d  = (!i_cmd_wr_clear_display && !i_cmd_wr_text_line1) ?
                      i_dat_ascii_line2 : i_dat_ascii_line1;
`endif
          end
        end
        ST_LOAD: begin
          tx_valid_d = 1'b1;
          tx_data_d  = cmd_byte(cmd_q, 5'd0, text_sel);
          idx_d      = 5'd0;
          state_d    = ST_SEND;
        end
        ST_SEND: begin
          if (tx_valid_q && i_tx_ready) begin
            if (idx_q == last_idx) begin
              tx_valid_d = 1'b0;
              state_d    = ST_DONE;
            end else begin
              // Next byte goes out on the same edge as the transfer.
              idx_d     = idx_q + 5'd1;
              tx_data_d = cmd_byte(cmd_q, idx_q + 5'd1, text_sel);
            end
          end
        end
        ST_DONE: begin
          idx_d   = 5'd0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CmdClear;
      idx_q      <= 5'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
`ifdef LCD_CLS_TEXT_LATCH_EN
      text_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      idx_q      <= idx_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
`ifdef LCD_CLS_TEXT_LATCH_EN
      text_q     <= text_d;
`endif
    end
  end

  assign o_command_ready = (state_q == ST_IDLE);
  assign o_cmd_done      = (state_q == ST_DONE);
  assign o_tx_valid      = tx_valid_q;
  assign o_tx_data       = tx_data_q;

endmodule

// File: doc/lcd_cls_cmd_serializer.md
LCD_CLS_CMD_SERIALIZER -- requirements
Module: lcd_cls_cmd_serializer

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset: i_clk_20mhz input 1 clock; i_rst_20mhz input 1 synchronous active-high reset.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- i_ce_2_5mhz  input  1  clock enable; all state, counter and handshake updates occur only on edges with it high.
- i_cmd_wr_clear_display  input  1  level request: clear the display.
- i_cmd_wr_text_line1  input  1  level request: write line 1.
- i_cmd_wr_text_line2  input  1  level request: write line 2.
- i_dat_ascii_line1  input  128  16 ASCII chars; [127:120] is leftmost.
- i_dat_ascii_line2  input  128  16 ASCII chars; [127:120] is leftmost.
- o_command_ready  output  1  high only in ST_IDLE.
- o_tx_data  output  8  byte to SPI byte transmitter.
- o_tx_valid  output  1  o_tx_data is valid.
- i_tx_ready  input  1  transmitter accepts a byte.
- o_cmd_done  output  1  one-ce-cycle pulse after the last byte of a command transfers.
REQ-003 The block SHALL have no parameters.

Function
REQ-004 The FSM states SHALL be ST_IDLE, ST_LOAD, ST_SEND, ST_DONE.
REQ-005 In ST_IDLE on a ce edge with any request high, the block SHALL accept exactly one command, prioritised clear > line1 > line2, and go to ST_LOAD.
REQ-006 The clear command SHALL emit exactly 3 bytes: 0x1B 0x5B 0x6A.
REQ-007 The line1 command SHALL emit 22 bytes: 0x1B 0x5B 0x30 0x3B 0x30 0x48, then the 16 chars of line 1, leftmost first.
REQ-008 The line2 command SHALL emit 22 bytes: 0x1B 0x5B 0x31 0x3B 0x30 0x48, then the 16 chars of line 2, leftmost first.
REQ-009 ST_LOAD SHALL present byte 0 with o_tx_valid=1 on the next ce edge and enter ST_SEND.
REQ-010 A byte SHALL transfer on a ce edge with o_tx_valid and i_tx_ready both high; o_tx_data SHALL stay stable while o_tx_valid is high and not yet transferred.
REQ-011 After a transfer, the next byte SHALL be presented on the same edge with o_tx_valid held high (back-to-back, one byte per ce cycle at full rate).
REQ-012 A 5-bit byte index SHALL count from 0; after the transfer at index 2 (clear) or 21 (line) the block SHALL drop o_tx_valid and enter ST_DONE.
REQ-013 ST_DONE SHALL assert o_cmd_done for one ce cycle, then return to ST_IDLE.
REQ-014 o_command_ready SHALL be combinational (state == ST_IDLE); it is low from the ce edge that accepts a command until ST_IDLE is re-entered.
REQ-015 Requests arriving while not in ST_IDLE SHALL be ignored, not queued; a request still high on return to ST_IDLE SHALL be accepted again.
REQ-016 i_tx_ready high while o_tx_valid is low SHALL have no effect.

Reset
REQ-017 On reset the block SHALL enter ST_IDLE, clear the index, and drive o_tx_valid=0, o_tx_data=0x00, o_cmd_done=0, and o_command_ready=1.
REQ-018 Reset mid-command SHALL abort the command; no further bytes of that command SHALL be emitted.
REQ-019 Reset SHALL take effect regardless of i_ce_2_5mhz.

Configuration
REQ-020 Macro LCD_CLS_TEXT_LATCH_EN SHALL control how the line text is sampled.
- Defined: the selected 128-bit line SHALL be latched on command acceptance; later input changes SHALL not affect the emitted chars.
- Undefined: each char SHALL be sampled live from the input bus when it is presented in ST_LOAD or ST_SEND.

Verification
REQ-021 Bench SHALL cover:
- Reset, then clear request with i_tx_ready=1 -> bytes 1B 5B 6A on 3 consecutive ce cycles, then o_cmd_done pulse, then o_command_ready=1.
- Line1 = "ACL X+0.00 Y+0.0" with i_tx_ready=1 -> 22 bytes 1B 5B 30 3B 30 48 41 43 4C ...; o_cmd_done after byte 21.
- Line2 with i_tx_ready toggling 1/0 every ce cycle -> same 22 bytes in order, no byte dropped or duplicated, o_tx_data stable while stalled.
- Clear, line1 and line2 all requested together -> clear sequence only; line1 accepted on the next return to ST_IDLE.
- Reset asserted after byte 5 of line1 -> o_tx_valid=0 on the next edge, o_command_ready=1, no further bytes.
- Change i_dat_ascii_line1 mid-transfer -> with LCD_CLS_TEXT_LATCH_EN, original chars are emitted; without it, the new chars appear from the next presented byte.
